// File: rtl/sd_write_photo.sv
// Saves one RGB565 frame to the SD card as raw consecutive sectors starting at START_SEC.
// Pixels come from a show-ahead FIFO; the final partial sector is padded with zero words.
module sd_write_photo #(
  parameter logic [31:0] START_SEC     = 32'd8192,
  parameter logic [23:0] PHOTO_H_PIXEL = 24'd800,
  parameter logic [23:0] PHOTO_V_PIXEL = 24'd480,
  parameter logic [15:0] BUSY_TO       = 16'd2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pix_rdy,
  input  logic [15:0] pix_data,
  output logic        pix_rd_en,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [23:0] TOTAL_WORDS = PHOTO_H_PIXEL * PHOTO_V_PIXEL;
  localparam logic [15:0] TOTAL_SEC   = 16'((TOTAL_WORDS + 24'd255) >> 8);

  typedef enum logic [2:0] {
    IDLE, WAIT_DATA, START_WR, WAIT_BUSY, XFER, NEXT_SEC, FINISH
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] sec_cnt_reg;
  logic [8:0]  word_cnt_reg;
  logic [23:0] frame_word_cnt_reg;
  logic [15:0] to_cnt_reg;
  logic [31:0] sec_addr_reg;
  logic [15:0] wr_data_reg;
  logic        busy_reg;
  logic        err_reg;

  logic frame_left;
  logic timeout;
  logic last_sec;

  assign frame_left = (frame_word_cnt_reg < TOTAL_WORDS);
  assign timeout    = ((to_cnt_reg + 16'd1) == BUSY_TO);
  assign last_sec   = ((sec_cnt_reg + 16'd1) == TOTAL_SEC);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (start) state_next = WAIT_DATA;
      WAIT_DATA: if (pix_rdy && !wr_busy) state_next = START_WR;
      START_WR:  state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (wr_busy)      state_next = XFER;
        else if (timeout) state_next = FINISH;
      end
      XFER:      if (!wr_busy) state_next = NEXT_SEC;
      NEXT_SEC:  state_next = last_sec ? FINISH : WAIT_DATA;
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_start_en = 1'b0;
    pix_rd_en   = 1'b0;
    done        = 1'b0;
    case (state_reg)
      START_WR: wr_start_en = 1'b1;
      XFER:     pix_rd_en   = wr_req && frame_left;
      FINISH:   done        = !err_reg;
      default:  ;
    endcase
  end

  // Datapath: counters, address, data word and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec_cnt_reg        <= 16'd0;
      word_cnt_reg       <= 9'd0;
      frame_word_cnt_reg <= 24'd0;
      to_cnt_reg         <= 16'd0;
      sec_addr_reg       <= START_SEC;
      wr_data_reg        <= 16'h0000;
      busy_reg           <= 1'b0;
      err_reg            <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy_reg           <= 1'b1;
            err_reg            <= 1'b0;
            sec_cnt_reg        <= 16'd0;
            frame_word_cnt_reg <= 24'd0;
            sec_addr_reg       <= START_SEC;
          end
        end
        START_WR: begin
          word_cnt_reg <= 9'd0;
          to_cnt_reg   <= 16'd0;
        end
        WAIT_BUSY: begin
          if (!wr_busy) begin
            if (timeout) err_reg <= 1'b1;
            else         to_cnt_reg <= to_cnt_reg + 16'd1;
          end
        end
        XFER: begin
          if (wr_req) begin
            word_cnt_reg <= word_cnt_reg + 9'd1;
            if (frame_left) begin
              wr_data_reg        <= pix_data;
              frame_word_cnt_reg <= frame_word_cnt_reg + 24'd1;
            end else begin
              wr_data_reg <= 16'h0000;
            end
          end
        end
        NEXT_SEC: begin
          if (word_cnt_reg != 9'd256) err_reg <= 1'b1;
          sec_cnt_reg  <= sec_cnt_reg + 16'd1;
          sec_addr_reg <= sec_addr_reg + 32'd1;
        end
        FINISH: busy_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign wr_sec_addr = sec_addr_reg;
  assign wr_data     = wr_data_reg;
  assign busy        = busy_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_sd_write_photo.sv
// Self-checking bench for sd_write_photo: a 24x40 frame (4 sectors, last one padded) is
// written through behavioural FIFO and SD-card models with randomized data and request gaps.
module tb_sd_write_photo;

  localparam logic [31:0] START_SEC = 32'd8192;
  localparam logic [23:0] H         = 24'd24;
  localparam logic [23:0] V         = 24'd40;
  localparam logic [15:0] BUSY_TO   = 16'd100;
  localparam int          TOTAL     = 960;
  localparam int          NSEC      = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, pix_rdy, wr_busy, wr_req;
  logic [15:0] pix_data;
  logic        pix_rd_en, wr_start_en, busy, done, err;
  logic [31:0] wr_sec_addr;
  logic [15:0] wr_data;

  always #5 clk = ~clk;

  sd_write_photo #(
    .START_SEC(START_SEC), .PHOTO_H_PIXEL(H), .PHOTO_V_PIXEL(V), .BUSY_TO(BUSY_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_rdy(pix_rdy), .pix_data(pix_data),
    .pix_rd_en(pix_rd_en), .wr_busy(wr_busy), .wr_req(wr_req), .wr_start_en(wr_start_en),
    .wr_sec_addr(wr_sec_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  // Show-ahead FIFO model holding the whole frame; pops on pix_rd_en.
  logic [15:0] frame_words [TOTAL];
  int          fifo_ptr = 0;
  int          pop_cnt  = 0;
  logic        fifo_clear = 1'b0;

  always @(posedge clk) begin
    if (fifo_clear) begin
      fifo_ptr <= 0;
      pop_cnt  <= 0;
    end else if (pix_rd_en) begin
      fifo_ptr <= fifo_ptr + 1;
      pop_cnt  <= pop_cnt + 1;
    end
  end

  assign pix_data = (fifo_ptr < TOTAL) ? frame_words[fifo_ptr[9:0]] : 16'h0000;

  int checks   = 0;
  int failures = 0;
  int ref_ptr  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame();
    for (int i = 0; i < TOTAL; i++) frame_words[i] = 16'($urandom);
    fifo_clear = 1'b1;
    tick();
    fifo_clear = 1'b0;
    ref_ptr = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_start_en(input int sec, output bit ok);
    int n = 0;
    while (!wr_start_en && n < 3000) begin
      tick();
      n++;
    end
    ok = wr_start_en;
    check("start_en_seen", 32'(ok), 32'd1);
    check("sec_addr", wr_sec_addr, START_SEC + 32'(sec));
  endtask

  // One sector as seen by the SD controller: nreq data requests with random gaps.
  task automatic sd_sector(input int sec, input int nreq, input bit hold_after);
    logic [15:0] exp;
    bit ok;
    wait_start_en(sec, ok);
    if (!ok) return;
    tick();
    check("start_en_one_cycle", 32'(wr_start_en), 32'd0);
    repeat ($urandom_range(0, 3)) tick();
    wr_busy = 1'b1;
    tick();
    for (int i = 0; i < nreq; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      wr_req = 1'b1;
      #1;
      exp = (ref_ptr < TOTAL) ? frame_words[ref_ptr] : 16'h0000;
      check("pix_rd_en", 32'(pix_rd_en), 32'(ref_ptr < TOTAL));
      if (ref_ptr < TOTAL) ref_ptr++;
      tick();
      wr_req = 1'b0;
      check("wr_data", 32'(wr_data), 32'(exp));
    end
    check("addr_stable", wr_sec_addr, START_SEC + 32'(sec));
    if (hold_after) pix_rdy = 1'b0;
    wr_busy = 1'b0;
    tick();
    tick();
    $display("sector %0d addr=%0d words=%0d fifo_pops=%0d err=%0b", sec, START_SEC + 32'(sec), nreq, pop_cnt, err);
  endtask

  task automatic run_frame(input int short_sec, input int hold_sec, input bit expect_err);
    int viol;
    for (int s = 0; s < NSEC; s++) begin
      sd_sector(s, (s == short_sec) ? 255 : 256, (s + 1) == hold_sec);
      if (s == short_sec) check("err_after_short_sector", 32'(err), 32'd1);
      if ((s + 1) == hold_sec) begin
        viol = 0;
        start = 1'b1;
        if (wr_start_en) viol++;
        tick();
        start = 1'b0;
        for (int i = 1; i < 500; i++) begin
          if (wr_start_en) viol++;
          tick();
        end
        check("hold_no_start_en", 32'(viol), 32'd0);
        pix_rdy = 1'b1;
      end
    end
    check("done_at_end", 32'(done), 32'(!expect_err));
    check("err_at_end", 32'(err), 32'(expect_err));
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_end", 32'(busy), 32'd0);
    check("pop_count", 32'(pop_cnt), 32'(TOTAL));
    $display("frame end pops=%0d err=%0b", pop_cnt, err);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; start = 1'b0; pix_rdy = 1'b1; wr_busy = 1'b0; wr_req = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_start_en", 32'(wr_start_en), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_addr", wr_sec_addr, START_SEC);
    rst_n = 1'b1;
    tick();

    // wr_req outside XFER must not pop or load data.
    wr_req = 1'b1;
    #1;
    check("idle_req_no_pop", 32'(pix_rd_en), 32'd0);
    tick();
    wr_req = 1'b0;
    check("idle_req_pop_cnt", 32'(pop_cnt), 32'd0);
    check("idle_req_wr_data", 32'(wr_data), 32'd0);

    // Normal frame, with a 500-cycle pix_rdy stall (and an ignored start) before sector 2.
    new_frame();
    pulse_start();
    check("latency_cycle1", 32'(wr_start_en), 32'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    tick();
    check("latency_cycle2", 32'(wr_start_en), 32'd1);
    run_frame(-1, 2, 1'b0);

    // Short sector: 255 requests in sector 1 flags err but the frame still completes.
    new_frame();
    pulse_start();
    run_frame(1, -1, 1'b1);

    // No wr_busy from the card: timeout after BUSY_TO cycles; start clears previous err.
    new_frame();
    pulse_start();
    check("start_clears_err", 32'(err), 32'd0);
    wait_start_en(0, ok);
    repeat (int'(BUSY_TO)) tick();
    check("err_before_timeout", 32'(err), 32'd0);
    tick();
    check("err_at_timeout", 32'(err), 32'd1);
    check("no_done_timeout", 32'(done), 32'd0);
    tick();
    check("busy_after_timeout", 32'(busy), 32'd0);
    check("no_done_after_timeout", 32'(done), 32'd0);
    $display("timeout frame err=%0b busy=%0b", err, busy);

    // Reset in the middle of a sector transfer, then a fresh frame.
    new_frame();
    pulse_start();
    wait_start_en(0, ok);
    tick();
    wr_busy = 1'b1;
    tick();
    wr_req = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0;
    wr_req = 1'b0;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_start_en", 32'(wr_start_en), 32'd0);
    check("midrst_rd_en", 32'(pix_rd_en), 32'd0);
    check("midrst_wr_data", 32'(wr_data), 32'd0);
    check("midrst_addr", wr_sec_addr, START_SEC);
    rst_n = 1'b1;
    wr_busy = 1'b0;
    $display("mid-transfer reset applied");
    new_frame();
    pulse_start();
    run_frame(-1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
